// File: rtl/aes_gcm_block_packer_if.sv
// Host word stream plus packed AAD/PT block bus between the packer and its neighbours.
// master = host/testbench side, slave = aes_gcm_block_packer.
interface aes_gcm_block_packer_if #(
  parameter int IN_W  = 32,
  parameter int LEN_W = 64
);
  logic [IN_W-1:0]   in_data;
  logic [IN_W/8-1:0] in_keep;
  logic              in_is_aad;
  logic              in_last;
  logic              in_valid;
  logic              in_ready;
  logic              dn_ready;
  logic [127:0]      aad_data;
  logic              aad_valid;
  logic              aad_last;
  logic [127:0]      pt_data;
  logic              pt_valid;
  logic              pt_last;
  logic [4:0]        pt_bytes_last;
  logic [LEN_W-1:0]  aad_len_bits;
  logic [LEN_W-1:0]  pt_len_bits;
  logic              len_valid;
  logic              err_order;

  modport master (
    output in_data, in_keep, in_is_aad, in_last, in_valid, dn_ready,
    input  in_ready, aad_data, aad_valid, aad_last, pt_data, pt_valid, pt_last,
           pt_bytes_last, aad_len_bits, pt_len_bits, len_valid, err_order
  );

  modport slave (
    input  in_data, in_keep, in_is_aad, in_last, in_valid, dn_ready,
    output in_ready, aad_data, aad_valid, aad_last, pt_data, pt_valid, pt_last,
           pt_bytes_last, aad_len_bits, pt_len_bits, len_valid, err_order
  );
endinterface

// File: rtl/aes_gcm_block_packer.sv
// Packs host AAD/PT words into zero-padded 128-bit big-endian blocks and tracks GHASH bit lengths.
// Define AES_GCM_PACK_BYTESWAP_EN for little-endian hosts (bytes reversed per word, keep LSB-contiguous).
module aes_gcm_block_packer #(
  parameter int IN_W  = 32,
  parameter int LEN_W = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  aes_gcm_block_packer_if.slave bus
);
  localparam int KW    = IN_W / 8;
  localparam int BEATS = 128 / IN_W;
  localparam int CW    = $clog2(BEATS + 1);

  typedef enum logic [1:0] {S_AAD, S_PT, S_LEN} state_t;

  state_t            state, state_nxt;
  logic [127:0]      acc, acc_ins, blk_data;
  logic [CW-1:0]     beat_cnt;
  logic              sec_started, pend, pend_aad, pend_data, pend_last, err;
  logic [LEN_W-1:0]  aad_len, pt_len, add_bits;
  logic [4:0]        bytes_last, n_bytes;
  logic [IN_W-1:0]   data_w, data_m;
  logic [KW-1:0]     keep_w;
  logic              in_rdy, accept, bad, good, blk_done, frame_start;

`ifdef AES_GCM_PACK_BYTESWAP_EN
  always_comb begin
    data_w = '0;
    keep_w = '0;
    for (int i = 0; i < KW; i++) begin
      data_w[i*8 +: 8] = bus.in_data[(KW-1-i)*8 +: 8];
      keep_w[i]        = bus.in_keep[KW-1-i];
    end
  end
`else
  assign data_w = bus.in_data;
  assign keep_w = bus.in_keep;
`endif

  always_comb begin
    n_bytes = '0;
    data_m  = '0;
    for (int i = 0; i < KW; i++) begin
      if (keep_w[i]) begin
        n_bytes          = n_bytes + 5'd1;
        data_m[i*8 +: 8] = data_w[i*8 +: 8];
      end
    end
  end

  // The accumulator is cleared after every block, so unwritten beats are the zero padding.
  always_comb begin
    acc_ins = acc;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_cnt == CW'(b)) acc_ins[(BEATS-1-b)*IN_W +: IN_W] = data_m;
    end
  end

  assign in_rdy      = ~(pend & ~bus.dn_ready) & (state != S_LEN);
  assign accept      = bus.in_valid & in_rdy;
  assign bad         = ((state == S_PT) & bus.in_is_aad)
                     | ((|keep_w) & ~(&keep_w) & ~bus.in_last)
                     | (~(|keep_w) & (~bus.in_last | sec_started));
  assign good        = accept & ~bad;
  assign blk_done    = bus.in_last | (beat_cnt == CW'(BEATS-1));
  assign frame_start = (state == S_AAD) & ~sec_started;
  assign add_bits    = LEN_W'({n_bytes, 3'b000});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_AAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_AAD:   if (good & bus.in_last) state_nxt = S_PT;
      S_PT:    if (good & bus.in_last) state_nxt = S_LEN;
      S_LEN:   state_nxt = S_AAD;
      default: state_nxt = S_AAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      blk_data    <= '0;
      beat_cnt    <= '0;
      sec_started <= 1'b0;
      pend        <= 1'b0;
      pend_aad    <= 1'b0;
      pend_data   <= 1'b0;
      pend_last   <= 1'b0;
      err         <= 1'b0;
      aad_len     <= '0;
      pt_len      <= '0;
      bytes_last  <= '0;
    end else begin
      if (pend & bus.dn_ready) pend <= 1'b0;
      if (accept & bad) err <= 1'b1;
      if (good) begin
        // Lengths of the previous frame stay visible until the next frame's first beat.
        if (state == S_AAD) begin
          aad_len <= (frame_start ? '0 : aad_len) + add_bits;
          if (frame_start) begin
            pt_len     <= '0;
            bytes_last <= '0;
          end
        end else begin
          pt_len <= pt_len + add_bits;
        end
        sec_started <= ~bus.in_last;
        if (blk_done) begin
          pend      <= 1'b1;
          blk_data  <= acc_ins;
          pend_aad  <= (state == S_AAD);
          pend_data <= |keep_w;
          pend_last <= bus.in_last;
          acc       <= '0;
          beat_cnt  <= '0;
          if ((state == S_PT) & bus.in_last)
            bytes_last <= 5'(beat_cnt) * 5'(KW) + n_bytes;
        end else begin
          acc      <= acc_ins;
          beat_cnt <= beat_cnt + CW'(1);
        end
      end
    end
  end

  assign bus.in_ready      = in_rdy;
  assign bus.len_valid     = (state == S_LEN);
  assign bus.aad_data      = pend_aad ? blk_data : '0;
  assign bus.aad_valid     = pend & pend_aad & pend_data;
  assign bus.aad_last      = pend & pend_aad & pend_last;
  assign bus.pt_data       = pend_aad ? '0 : blk_data;
  assign bus.pt_valid      = pend & ~pend_aad & pend_data;
  assign bus.pt_last       = pend & ~pend_aad & pend_last;
  assign bus.pt_bytes_last = bytes_last;
  assign bus.aad_len_bits  = aad_len;
  assign bus.pt_len_bits   = pt_len;
  assign bus.err_order     = err;
endmodule

// File: tb/tb_aes_gcm_block_packer.sv
// Directed bench for aes_gcm_block_packer (IN_W=32): empty sections, NIST words, padding, stall, errors, reset.
module tb_aes_gcm_block_packer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_gcm_block_packer_if #(.IN_W(32), .LEN_W(64)) bus ();
  aes_gcm_block_packer #(.IN_W(32), .LEN_W(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;
  int waits  = 0;
  logic [127:0] pt_q[$];
  logic [127:0] aad_q[$];
  logic         pt_lastq[$];
  int           aad_mark, pt_mark, lv_cnt;
  logic [63:0]  lv_aad, lv_pt;
  logic [4:0]   lv_bytes;
  logic [127:0] held;
  bit           seen;

  logic [31:0] nist [16] = '{32'hd9313225, 32'hf88406e5, 32'ha55909c5, 32'haff5269a,
                             32'h86a7a953, 32'h1534f7da, 32'h2e4c303d, 32'h8a318a72,
                             32'h1c3c0c95, 32'h95680953, 32'h2fcf0e24, 32'h49a6b525,
                             32'hb16aedf5, 32'haa0de657, 32'hba637b39, 32'h1aafd255};

  always @(posedge clk) begin
    if (rst_n && bus.dn_ready) begin
      if (bus.pt_valid) begin
        pt_q.push_back(bus.pt_data);
        pt_lastq.push_back(bus.pt_last);
      end
      if (bus.aad_valid) aad_q.push_back(bus.aad_data);
      if (bus.aad_last && !bus.aad_valid) aad_mark++;
      if (bus.pt_last && !bus.pt_valid) pt_mark++;
    end
    if (rst_n && bus.len_valid) begin
      lv_cnt++;
      lv_aad   = bus.aad_len_bits;
      lv_pt    = bus.pt_len_bits;
      lv_bytes = bus.pt_bytes_last;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic aad, input logic last);
    bit got = 0;
    @(negedge clk);
    bus.in_data = d; bus.in_keep = k; bus.in_is_aad = aad; bus.in_last = last; bus.in_valid = 1'b1;
    for (int t = 0; t < 100 && !got; t++) begin
      #1;
      if (bus.in_ready) begin
        @(posedge clk);
        got = 1;
      end else begin
        waits++;
        @(negedge clk);
      end
    end
    chk("send_accept", 128'(got), 128'd1);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_nist(input int n);
    for (int i = 0; i < n; i++) send(nist[i], 4'hf, 1'b0, i == n - 1);
  endtask

  task automatic clr();
    pt_q.delete(); aad_q.delete(); pt_lastq.delete();
    aad_mark = 0; pt_mark = 0; lv_cnt = 0; waits = 0;
    lv_aad = '1; lv_pt = '1; lv_bytes = '1;
  endtask

  task automatic check_idle(input string p);
    chk({p, "_in_ready"}, 128'(bus.in_ready), 128'd1);
    chk({p, "_aad_valid"}, 128'(bus.aad_valid), 128'd0);
    chk({p, "_aad_last"}, 128'(bus.aad_last), 128'd0);
    chk({p, "_pt_valid"}, 128'(bus.pt_valid), 128'd0);
    chk({p, "_pt_last"}, 128'(bus.pt_last), 128'd0);
    chk({p, "_len_valid"}, 128'(bus.len_valid), 128'd0);
    chk({p, "_err_order"}, 128'(bus.err_order), 128'd0);
    chk({p, "_aad_len"}, 128'(bus.aad_len_bits), 128'd0);
    chk({p, "_pt_len"}, 128'(bus.pt_len_bits), 128'd0);
    chk({p, "_pt_bytes"}, 128'(bus.pt_bytes_last), 128'd0);
    chk({p, "_aad_data"}, bus.aad_data, 128'd0);
    chk({p, "_pt_data"}, bus.pt_data, 128'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_data = '0; bus.in_keep = '0; bus.in_is_aad = 1'b0; bus.in_last = 1'b0;
    bus.in_valid = 1'b0; bus.dn_ready = 1'b1;
    clr();
    repeat (2) @(negedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // T1: empty AAD, one all-zero PT block
    clr();
    send(32'h0, 4'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send(32'h0, 4'hf, 1'b0, i == 3);
    idle(5);
    chk("t1_aad_mark", 128'(aad_mark), 128'd1);
    chk("t1_aad_blocks", 128'(aad_q.size()), 128'd0);
    chk("t1_pt_blocks", 128'(pt_q.size()), 128'd1);
    chk("t1_pt_data", pt_q[0], 128'd0);
    chk("t1_pt_last", 128'(pt_lastq[0]), 128'd1);
    chk("t1_len_pulses", 128'(lv_cnt), 128'd1);
    chk("t1_pt_bytes", 128'(lv_bytes), 128'd16);
    chk("t1_pt_len", 128'(lv_pt), 128'd128);
    chk("t1_aad_len", 128'(lv_aad), 128'd0);
    chk("t1_pt_len_held", 128'(bus.pt_len_bits), 128'd128);

    // T2: both sections empty
    clr();
    send(32'h0, 4'h0, 1'b1, 1'b1);
    send(32'h0, 4'h0, 1'b0, 1'b1);
    idle(5);
    chk("t2_aad_mark", 128'(aad_mark), 128'd1);
    chk("t2_pt_mark", 128'(pt_mark), 128'd1);
    chk("t2_pt_blocks", 128'(pt_q.size()), 128'd0);
    chk("t2_pt_bytes", 128'(lv_bytes), 128'd0);
    chk("t2_pt_len", 128'(lv_pt), 128'd0);
    chk("t2_aad_len", 128'(lv_aad), 128'd0);

    // T3: 64-byte NIST plaintext, no stall
    clr();
    send(32'h0, 4'h0, 1'b1, 1'b1);
    send_nist(16);
    idle(5);
    chk("t3_waits", 128'(waits), 128'd0);
    chk("t3_pt_blocks", 128'(pt_q.size()), 128'd4);
    chk("t3_blk0", pt_q[0], 128'hd9313225f88406e5a55909c5aff5269a);
    chk("t3_blk3", pt_q[3], 128'hb16aedf5aa0de657ba637b391aafd255);
    chk("t3_last0", 128'(pt_lastq[0]), 128'd0);
    chk("t3_last3", 128'(pt_lastq[3]), 128'd1);
    chk("t3_pt_len", 128'(lv_pt), 128'd512);
    chk("t3_pt_bytes", 128'(lv_bytes), 128'd16);

    // T4: 20-byte AAD, 60-byte PT
    clr();
    send(32'hfeedface, 4'hf, 1'b1, 1'b0);
    send(32'hdeadbeef, 4'hf, 1'b1, 1'b0);
    send(32'hfeedface, 4'hf, 1'b1, 1'b0);
    send(32'hdeadbeef, 4'hf, 1'b1, 1'b0);
    send(32'habaddad2, 4'hf, 1'b1, 1'b1);
    send_nist(15);
    idle(5);
    chk("t4_aad_blocks", 128'(aad_q.size()), 128'd2);
    chk("t4_aad_blk0", aad_q[0], 128'hfeedfacedeadbeeffeedfacedeadbeef);
    chk("t4_aad_blk1", aad_q[1], 128'habaddad2000000000000000000000000);
    chk("t4_pt_blk3", pt_q[3], 128'hb16aedf5aa0de657ba637b3900000000);
    chk("t4_aad_len", 128'(lv_aad), 128'ha0);
    chk("t4_pt_len", 128'(lv_pt), 128'h1e0);
    chk("t4_pt_bytes", 128'(lv_bytes), 128'd12);

    // T4b: partial last word, 5 PT bytes
    clr();
    send(32'h0, 4'h0, 1'b1, 1'b1);
    send(32'h11223344, 4'hf, 1'b0, 1'b0);
    send(32'h55667788, 4'b1000, 1'b0, 1'b1);
    idle(5);
    chk("t4b_pt_blk", pt_q[0], 128'h11223344550000000000000000000000);
    chk("t4b_pt_bytes", 128'(lv_bytes), 128'd5);
    chk("t4b_pt_len", 128'(lv_pt), 128'd40);

    // T5: NIST plaintext with a 5-cycle stall on the second block
    clr();
    seen = 0;
    send(32'h0, 4'h0, 1'b1, 1'b1);
    fork
      send_nist(16);
      begin
        for (int t = 0; t < 200 && !seen; t++) begin
          @(negedge clk);
          if (bus.pt_valid && pt_q.size() == 1) seen = 1;
        end
        chk("t5_blk2_seen", 128'(seen), 128'd1);
        bus.dn_ready = 1'b0;
        held = bus.pt_data;
        repeat (5) begin
          #1;
          chk("t5_stall_valid", 128'(bus.pt_valid), 128'd1);
          chk("t5_stall_ready", 128'(bus.in_ready), 128'd0);
          chk("t5_stall_data", bus.pt_data, held);
          @(negedge clk);
        end
        bus.dn_ready = 1'b1;
      end
    join
    idle(5);
    chk("t5_held_blk", held, 128'h86a7a9531534f7da2e4c303d8a318a72);
    chk("t5_pt_blocks", 128'(pt_q.size()), 128'd4);
    chk("t5_blk1", pt_q[1], 128'h86a7a9531534f7da2e4c303d8a318a72);
    chk("t5_blk3", pt_q[3], 128'hb16aedf5aa0de657ba637b391aafd255);
    chk("t5_pt_len", 128'(lv_pt), 128'd512);

    // T6a: protocol errors are dropped and flagged
    clr();
    send(32'h0, 4'h0, 1'b1, 1'b1);
    send(32'h11111111, 4'hf, 1'b0, 1'b0);
    send(32'hdeadbeef, 4'hf, 1'b1, 1'b0);
    idle(0);
    #1;
    chk("t6_err_set", 128'(bus.err_order), 128'd1);
    send(32'haabbccdd, 4'b1100, 1'b0, 1'b0);
    send(32'h00000000, 4'h0, 1'b0, 1'b0);
    send(32'h22222222, 4'hf, 1'b0, 1'b0);
    send(32'h33333333, 4'hf, 1'b0, 1'b0);
    send(32'h44444444, 4'hf, 1'b0, 1'b1);
    idle(5);
    chk("t6_pt_blocks", 128'(pt_q.size()), 128'd1);
    chk("t6_pt_blk", pt_q[0], 128'h11111111222222223333333344444444);
    chk("t6_pt_len", 128'(lv_pt), 128'd128);
    chk("t6_err_sticky", 128'(bus.err_order), 128'd1);

    // T6b: reset mid-frame discards the partial block
    clr();
    send(32'h0, 4'h0, 1'b1, 1'b1);
    send(32'h99999999, 4'hf, 1'b0, 1'b0);
    send(32'h88888888, 4'hf, 1'b0, 1'b0);
    idle(0);
    rst_n = 1'b0;
    #1;
    check_idle("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    send(32'h0, 4'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send(32'h55555555 + 32'(i), 4'hf, 1'b0, i == 3);
    idle(5);
    chk("t6_clean_blocks", 128'(pt_q.size()), 128'd1);
    chk("t6_clean_blk", pt_q[0], 128'h55555555555555565555555755555558);
    chk("t6_clean_len", 128'(lv_pt), 128'd128);
    chk("t6_clean_err", 128'(bus.err_order), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
